// File: rtl/fp16_add_arbiter_if.sv
// Requester-side bundle for fp16_add_arbiter: operand request channel and
// per-requester result channel, packed 16 bits per requester.
interface fp16_add_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [16*NREQ-1:0] req_a;
    logic [16*NREQ-1:0] req_b;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [16*NREQ-1:0] rsp_z;

    // Compute lanes: issue operands, consume results.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_z
    );

    // Arbiter: accept operands, present results.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_z
    );
endinterface

// File: rtl/fp16_add_arbiter.sv
// Round-robin arbiter sharing one external FP16 adder among NREQ requesters.
// One issue per cycle; each requester owns a single-entry result slot that is
// drained with rsp_valid/rsp_ready. Optional statistics counters are built
// when FP16_ARB_STATS_EN is defined; otherwise op_count/stall_count read 0.
module fp16_add_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 3
) (
    input  logic              clk,
    input  logic              rst,
    fp16_add_arbiter_if.slave req_bus,
    output logic              add_en,
    output logic [15:0]       add_a,
    output logic [15:0]       add_b,
    input  logic [15:0]       add_z,
    input  logic              add_ready,
    output logic              busy,
    output logic              err,
    output logic [31:0]       op_count,
    output logic [31:0]       stall_count
);
    localparam int unsigned NR = NREQ;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      tag;
    logic [PW-1:0]      gidx;
    logic               inflight_v;
    logic               found;
    logic [NREQ-1:0]    elig;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    slot_full;
    logic [16*NREQ-1:0] slot;

    // A requester may issue only when none of its results is in flight or held.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            elig[i] = req_bus.req_valid[i] & ~slot_full[i] & ~(inflight_v && (tag == PW'(i)));
        end
    end

    // Round-robin search from ptr upward, wrapping; forced idle during reset.
    always_comb begin
        int unsigned j;
        int unsigned sel;
        j     = 0;
        sel   = 0;
        found = 1'b0;
        grant = '0;
        gidx  = '0;
        add_a = '0;
        add_b = '0;
        if (!rst) begin
            for (int unsigned k = 0; k < NR; k++) begin
                j = 32'(ptr) + k;
                if (j >= NR) begin
                    j = j - NR;
                end
                if (!found && elig[j]) begin
                    found = 1'b1;
                    sel   = j;
                end
            end
        end
        if (found) begin
            gidx  = PW'(sel);
            grant = (NREQ)'(1) << sel;
            add_a = 16'(req_bus.req_a >> (16 * sel));
            add_b = 16'(req_bus.req_b >> (16 * sel));
        end
    end

    assign req_bus.req_ready = grant;
    assign add_en            = found;
    assign req_bus.rsp_valid = slot_full;
    assign req_bus.rsp_z     = slot;
    assign busy              = inflight_v | (|slot_full);

    // Issue tracking: pointer advance, in-flight tag, sticky missing-result error.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            tag        <= '0;
            inflight_v <= 1'b0;
            err        <= 1'b0;
        end else begin
            inflight_v <= found;
            if (found) begin
                tag <= gidx;
                ptr <= (gidx == PW'(NR - 1)) ? '0 : gidx + 1'b1;
            end
            if (inflight_v && !add_ready) begin
                err <= 1'b1;
            end
        end
    end

    // Result slots: capture the adder output for the tagged requester, clear on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full <= '0;
            slot      <= '0;
        end else begin
            for (int unsigned i = 0; i < NR; i++) begin
                if (inflight_v && add_ready && (tag == PW'(i))) begin
                    slot_full[i]     <= 1'b1;
                    slot[16*i +: 16] <= add_z;
                end else if (slot_full[i] && req_bus.rsp_ready[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    end

`ifdef FP16_ARB_STATS_EN
    logic [31:0] op_cnt;
    logic [31:0] stall_cnt;

    // Saturating counters: completed captures and cycles with demand but no grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (inflight_v && add_ready && (op_cnt != '1)) begin
                op_cnt <= op_cnt + 1'b1;
            end
            if ((|req_bus.req_valid) && !found && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign op_count    = op_cnt;
    assign stall_count = stall_cnt;
`else
    assign op_count    = '0;
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Scoreboard bench for fp16_add_arbiter with a behavioural stub adder.
// Operands are small integers (or simple fractions) so real-valued sums are
// exactly representable in FP16.
module tb_fp16_add_arbiter;
    localparam int NREQ = 4;
    localparam int PW   = 3;

`ifdef FP16_ARB_STATS_EN
    localparam longint EXP_OPS    = 10;
    localparam longint EXP_STALLS = 3;
`else
    localparam longint EXP_OPS    = 0;
    localparam longint EXP_STALLS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        add_en;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] add_z;
    logic        add_ready;
    logic        busy;
    logic        err;
    logic [31:0] op_count;
    logic [31:0] stall_count;

    fp16_add_arbiter_if #(.NREQ(NREQ)) bus ();

    fp16_add_arbiter #(.NREQ(NREQ), .PW(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_bus     (bus),
        .add_en      (add_en),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_z       (add_z),
        .add_ready   (add_ready),
        .busy        (busy),
        .err         (err),
        .op_count    (op_count),
        .stall_count (stall_count)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FP16 <-> real for normal numbers and zero.
    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        if (h[14:0] == 15'd0) return 0.0;
        m = 1.0 + real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real v);
        logic s;
        real  m;
        int   e;
        int   man;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        man = int'((m - 1.0) * 1024.0);
        return {s, 5'(e + 15), 10'(man)};
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        return r2h(h2r(a) + h2r(b));
    endfunction

    function automatic logic [15:0] rand_h();
        int n;
        n = int'($urandom_range(2000)) - 1000;
        return r2h(real'(n));
    endfunction

    // Stub adder: samples operands on an issue edge, answers during the next cycle.
    logic        adder_ok;
    logic        pipe_v = 1'b0;
    logic [15:0] pipe_z = 16'h0;
    always @(posedge clk) begin
        pipe_v <= add_en;
        pipe_z <= ref_add(add_a, add_b);
    end
    assign add_ready = pipe_v & adder_ok;
    assign add_z     = pipe_z;

    typedef struct {
        int          idx;
        logic [15:0] z;
        int          due;
    } sb_t;
    sb_t sb[$];

    // Reference model state
    int              m_ptr;
    int              m_infl;
    logic [NREQ-1:0] m_held;
    logic            m_err;
    longint          m_ops;
    longint          m_stalls;

    // Model: predict grant and visible state, push expected results on issue.
    always @(negedge clk) begin : model_p
        int              g;
        int              j;
        logic [NREQ-1:0] exp_grant;
        logic [15:0]     ga;
        logic [15:0]     gb;
        if (rst) begin
            check("rst_req_ready", 64'(bus.req_ready), 64'd0);
            check("rst_add_en", 64'(add_en), 64'd0);
            m_ptr    = 0;
            m_infl   = -1;
            m_held   = '0;
            m_err    = 1'b0;
            m_ops    = 0;
            m_stalls = 0;
            sb.delete();
        end else begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (g < 0 && bus.req_valid[j] && !m_held[j] && m_infl != j) g = j;
            end
            exp_grant = '0;
            ga = 16'h0;
            gb = 16'h0;
            if (g >= 0) begin
                exp_grant[g] = 1'b1;
                ga = bus.req_a[16*g +: 16];
                gb = bus.req_b[16*g +: 16];
            end
            check("req_ready", 64'(bus.req_ready), 64'(exp_grant));
            check("add_en", 64'(add_en), 64'(g >= 0));
            check("add_a", 64'(add_a), 64'(ga));
            check("add_b", 64'(add_b), 64'(gb));
            check("rsp_valid", 64'(bus.rsp_valid), 64'(m_held));
            check("busy", 64'(busy), 64'((m_infl >= 0) || (|m_held)));
            check("err", 64'(err), 64'(m_err));
`ifdef FP16_ARB_STATS_EN
            check("op_count", 64'(op_count), 64'(m_ops));
            check("stall_count", 64'(stall_count), 64'(m_stalls));
`else
            check("op_count", 64'(op_count), 64'd0);
            check("stall_count", 64'(stall_count), 64'd0);
`endif
            if (g >= 0) sb.push_back('{idx: g, z: ref_add(ga, gb), due: cyc + 2});
            m_held = m_held & ~bus.rsp_ready;
            if (m_infl >= 0) begin
                if (adder_ok) begin
                    m_held[m_infl] = 1'b1;
                    if (m_ops < 64'hFFFF_FFFF) m_ops++;
                end else begin
                    m_err = 1'b1;
                    for (int q = sb.size() - 1; q >= 0; q--) begin
                        if (sb[q].idx == m_infl) sb.delete(q);
                    end
                end
            end
            if ((|bus.req_valid) && g < 0 && m_stalls < 64'hFFFF_FFFF) m_stalls++;
            m_infl = g;
            if (g >= 0) m_ptr = (g + 1) % NREQ;
        end
    end

    // Monitor: check result latency on rsp_valid rise and data on drain.
    logic [NREQ-1:0] prev_rv = '0;
    always @(negedge clk) begin : mon_p
        int f;
        if (rst) begin
            prev_rv = '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                f = -1;
                for (int q = 0; q < sb.size(); q++) begin
                    if (f < 0 && sb[q].idx == i) f = q;
                end
                if (bus.rsp_valid[i] && !prev_rv[i]) begin
                    if (f < 0) check("rsp_unexpected", 64'd1, 64'd0);
                    else check("rsp_latency", 64'(cyc), 64'(sb[f].due));
                end
                if (bus.rsp_valid[i] && bus.rsp_ready[i] && f >= 0) begin
                    check("rsp_z", 64'(bus.rsp_z[16*i +: 16]), 64'(sb[f].z));
                    sb.delete(f);
                end
            end
            prev_rv = bus.rsp_valid;
        end
    end

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[16*i +: 16] = a;
        bus.req_b[16*i +: 16] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int w;
        rst           = 1'b1;
        adder_ok      = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_op_count", 64'(op_count), 64'd0);
        check("reset_stall_count", 64'(stall_count), 64'd0);
        tick();
        rst = 1'b0;

        // Single op: 1.0 + 2.0 = 3.0
        set_op(0, 16'h3C00, 16'h4000);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        check("single_grant", 64'(bus.req_ready), 64'b0001);
        tick();
        bus.req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        check("single_rsp_valid", 64'(bus.rsp_valid[0]), 64'd1);
        check("single_rsp_z", 64'(bus.rsp_z[15:0]), 64'h4200);
        tick();
        @(negedge clk);
        check("single_busy_idle", 64'(busy), 64'd0);

        // Full load: 0.5 + 0.5 from every requester, one issue per cycle
        tick();
        for (int i = 0; i < NREQ; i++) set_op(i, 16'h3800, 16'h3800);
        bus.req_valid = '1;
        repeat (12) begin
            @(negedge clk);
            check("full_load_no_gap", 64'(add_en), 64'd1);
        end
        tick();
        bus.req_valid = '0;
        repeat (4) tick();

        // Backpressure on requester 1: 1.5 + (-1.0) = 0.5 held in slot 1
        bus.rsp_ready = 4'b1101;
        set_op(1, 16'h3E00, 16'hBC00);
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b1111;
        repeat (10) begin
            for (int i = 0; i < NREQ; i++) if (i != 1) set_op(i, rand_h(), rand_h());
            tick();
        end
        @(negedge clk);
        check("bp_rsp_valid1", 64'(bus.rsp_valid[1]), 64'd1);
        check("bp_rsp_z1", 64'(bus.rsp_z[31:16]), 64'h3800);
        tick();
        bus.req_valid    = 4'b0010;
        bus.rsp_ready[1] = 1'b1;
        tick();
        bus.rsp_ready[1] = 1'b0;
        @(negedge clk);
        check("bp_regrant", 64'(bus.req_ready), 64'b0010);
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        repeat (4) tick();

        // Reset in the cycle after a requester-2 handshake
        set_op(2, rand_h(), rand_h());
        bus.req_valid = 4'b0100;
        @(negedge clk);
        check("rmo_grant", 64'(bus.req_ready), 64'b0100);
        tick();
        rst           = 1'b1;
        bus.req_valid = '0;
        tick();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rmo_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            check("rmo_busy", 64'(busy), 64'd0);
        end
        tick();
        set_op(1, rand_h(), rand_h());
        set_op(3, rand_h(), rand_h());
        bus.req_valid = 4'b1010;
        @(negedge clk);
        check("rmo_first_grant", 64'(bus.req_ready), 64'b0010);
        tick();
        bus.req_valid = '0;
        repeat (4) tick();

        // Randomized traffic
        repeat (400) begin
            for (int i = 0; i < NREQ; i++) begin
                set_op(i, rand_h(), rand_h());
                bus.req_valid[i] = 1'($urandom_range(1));
                bus.rsp_ready[i] = ($urandom_range(3) != 0);
            end
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        repeat (4) tick();

        // Statistics: 10 completed ops, then 3 cycles blocked by a full slot
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            set_op(0, rand_h(), rand_h());
            if (n == 9) bus.rsp_ready[0] = 1'b0;
            bus.req_valid = 4'b0001;
            tick();
            bus.req_valid = '0;
            repeat (3) tick();
        end
        bus.req_valid = 4'b0001;
        repeat (3) tick();
        bus.req_valid = '0;
        @(negedge clk);
        check("stats_op_count", 64'(op_count), 64'(EXP_OPS));
        check("stats_stall_count", 64'(stall_count), 64'(EXP_STALLS));
        tick();
        bus.rsp_ready = '1;
        repeat (3) tick();

        // Protocol error: adder never answers
        rst      = 1'b1;
        adder_ok = 1'b0;
        tick();
        rst = 1'b0;
        set_op(0, rand_h(), rand_h());
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        repeat (2) tick();
        @(negedge clk);
        check("perr_err", 64'(err), 64'd1);
        check("perr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        repeat (5) tick();
        @(negedge clk);
        check("perr_sticky", 64'(err), 64'd1);
        tick();
        rst      = 1'b1;
        adder_ok = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("perr_cleared", 64'(err), 64'd0);

        // Final drain with a bounded wait
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        w = 0;
        while (busy && w < 50) begin
            tick();
            w++;
        end
        check("drain_busy", 64'(busy), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
